// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / mul-div hazard detection with stall-cycle counter
module hazard_stall_ctrl #(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 2,
    parameter int MD_LAT   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic             id_use_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rt,
    input  logic             id_is_md,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [RA_W-1:0]  ex_dest,
    input  logic             ex_md_start,
    input  logic             flush,
    output logic             stall,
    output logic             bubble_ex,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Loads older than EX that still block a consumer; at least one slot so the types stay legal.
    localparam int QN = (LOAD_LAT > 2) ? LOAD_LAT - 2 : 1;
    // md_cnt must hold MD_LAT-1.
    localparam int MW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [MW:0] MD_TWO = 2;

    logic          ex_load;
    logic          ex_md;
    logic          q_hit;
    logic          ld_hit;
    logic          md_hit;
    logic          md_ge2;
    logic [MW-1:0] md_cnt;
    logic [RA_W-1:0] md_dest;

    // A source matches d only if it is actually read and is not the hardwired zero register.
    function automatic logic src_hit(input logic use_s, input logic [RA_W-1:0] s,
                                     input logic [RA_W-1:0] d);
        return use_s && (s != '0) && (s == d);
    endfunction

    assign ex_load = ex_valid & ex_memread;
    assign ex_md   = ex_valid & ex_md_start;
    assign md_ge2  = ({1'b0, md_cnt} >= MD_TWO);

    generate
        if (LOAD_LAT > 2) begin : g_q
            logic [QN-1:0]   q_valid;
            logic [RA_W-1:0] q_dest [QN];

            // Age loads by one slot every cycle, stalled or not.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_valid <= '0;
                    for (int k = 0; k < QN; k++) q_dest[k] <= '0;
                end else begin
                    q_valid[0] <= ex_load;
                    q_dest[0]  <= ex_dest;
                    for (int k = 1; k < QN; k++) begin
                        q_valid[k] <= q_valid[k-1];
                        q_dest[k]  <= q_dest[k-1];
                    end
                end
            end

            // Any still-young older load writing a register the ID instruction reads.
            always_comb begin
                q_hit = 1'b0;
                for (int k = 0; k < QN; k++) begin
                    if (q_valid[k] && (src_hit(id_use_rs, id_rs, q_dest[k]) ||
                                       src_hit(id_use_rt, id_rt, q_dest[k])))
                        q_hit = 1'b1;
                end
            end
        end else begin : g_noq
            assign q_hit = 1'b0;
        end
    endgenerate

    // Load hazard against the load currently in EX plus the queued ones.
    always_comb begin
        ld_hit = q_hit;
        if ((LOAD_LAT >= 2) && ex_load &&
            (src_hit(id_use_rs, id_rs, ex_dest) || src_hit(id_use_rt, id_rt, ex_dest)))
            ld_hit = 1'b1;
    end

    // Mul/div hazard: data dependence on the running or starting op, or a second md op (structural).
    always_comb begin
        md_hit = 1'b0;
        if (md_ge2 && (id_is_md || src_hit(id_use_rs, id_rs, md_dest) ||
                       src_hit(id_use_rt, id_rt, md_dest)))
            md_hit = 1'b1;
        if ((MD_LAT >= 2) && ex_md && (id_is_md || src_hit(id_use_rs, id_rs, ex_dest) ||
                                       src_hit(id_use_rt, id_rt, ex_dest)))
            md_hit = 1'b1;
    end

    assign stall     = id_valid & ~flush & (ld_hit | md_hit);
    assign bubble_ex = stall;
    assign md_busy   = (md_cnt != '0) | ex_md;

    // Mul/div occupancy countdown; a new start restarts it with its own destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt  <= '0;
            md_dest <= '0;
        end else if (ex_md) begin
            md_cnt  <= MW'(MD_LAT - 1);
            md_dest <= ex_dest;
        end else if (md_cnt != '0) begin
            md_cnt  <= md_cnt - MW'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - randomized and directed checks of hazard_stall_ctrl against an age-based model
module tb_hazard_stall_ctrl;

    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_is_md = 0;
    logic [4:0] id_rs = 0, id_rt = 0, ex_dest = 0;
    logic       ex_valid = 0, ex_memread = 0, ex_md_start = 0, flush = 0;

    logic        st   [ND];
    logic        bb   [ND];
    logic        mb   [ND];
    logic [15:0] cnt  [ND];
    logic [1:0]  cnt_b;
    logic [7:0]  cnt_d;

    int n_chk = 0;
    int n_err = 0;

    // Model history: index a-1 holds what EX did a cycles ago.
    logic       hld_v [8];
    logic [4:0] hld_d [8];
    logic       hmd_v [8];
    logic [4:0] hmd_d [8];
    int         mcnt  [ND];

    always #5 clk = ~clk;

    function automatic int ll(input int i);
        case (i) 0: return 2; 1: return 3; 2: return 1; default: return 4; endcase
    endfunction
    function automatic int ml(input int i);
        case (i) 0: return 4; 1: return 4; 2: return 1; default: return 6; endcase
    endfunction
    function automatic int cmax(input int i);
        case (i) 1: return 3; 3: return 255; default: return 65535; endcase
    endfunction

    hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(2), .MD_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use_rs(id_use_rs),
        .id_rt(id_rt), .id_use_rt(id_use_rt), .id_is_md(id_is_md), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_dest(ex_dest), .ex_md_start(ex_md_start), .flush(flush),
        .stall(st[0]), .bubble_ex(bb[0]), .md_busy(mb[0]), .stall_cnt(cnt[0]));
    hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use_rs(id_use_rs),
        .id_rt(id_rt), .id_use_rt(id_use_rt), .id_is_md(id_is_md), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_dest(ex_dest), .ex_md_start(ex_md_start), .flush(flush),
        .stall(st[1]), .bubble_ex(bb[1]), .md_busy(mb[1]), .stall_cnt(cnt_b));
    hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(1), .MD_LAT(1), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use_rs(id_use_rs),
        .id_rt(id_rt), .id_use_rt(id_use_rt), .id_is_md(id_is_md), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_dest(ex_dest), .ex_md_start(ex_md_start), .flush(flush),
        .stall(st[2]), .bubble_ex(bb[2]), .md_busy(mb[2]), .stall_cnt(cnt[2]));
    hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(4), .MD_LAT(6), .CNT_W(8)) dut_d (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use_rs(id_use_rs),
        .id_rt(id_rt), .id_use_rt(id_use_rt), .id_is_md(id_is_md), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_dest(ex_dest), .ex_md_start(ex_md_start), .flush(flush),
        .stall(st[3]), .bubble_ex(bb[3]), .md_busy(mb[3]), .stall_cnt(cnt_d));

    assign cnt[1] = {14'b0, cnt_b};
    assign cnt[3] = {8'b0, cnt_d};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] d);
        return (id_use_rs && id_rs != 0 && id_rs == d) || (id_use_rt && id_rt != 0 && id_rt == d);
    endfunction

    // Age of the newest past mul/div start, 0 if none in the window.
    function automatic int md_age();
        for (int a = 1; a <= 8; a++) if (hmd_v[a-1]) return a;
        return 0;
    endfunction

    function automatic bit m_stall(input int i);
        bit haz = 0;
        int ma = md_age();
        if (!id_valid || flush) return 0;
        if (ll(i) >= 2 && ex_valid && ex_memread && reads(ex_dest)) haz = 1;
        for (int a = 1; a <= ll(i) - 2; a++) if (hld_v[a-1] && reads(hld_d[a-1])) haz = 1;
        if (ml(i) >= 2 && ex_valid && ex_md_start && (reads(ex_dest) || id_is_md)) haz = 1;
        if (ma > 0 && ma <= ml(i) - 2 && (reads(hmd_d[ma-1]) || id_is_md)) haz = 1;
        return haz;
    endfunction

    function automatic bit m_busy(input int i);
        int ma = md_age();
        return (ex_valid && ex_md_start) || (ma > 0 && ma <= ml(i) - 1);
    endfunction

    // Reference history and expected counters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 8; a++) begin
                hld_v[a] <= 0; hld_d[a] <= 0; hmd_v[a] <= 0; hmd_d[a] <= 0;
            end
            for (int i = 0; i < ND; i++) mcnt[i] <= 0;
        end else begin
            for (int i = 0; i < ND; i++)
                if (m_stall(i) && mcnt[i] < cmax(i)) mcnt[i] <= mcnt[i] + 1;
            hld_v[0] <= ex_valid && ex_memread; hld_d[0] <= ex_dest;
            hmd_v[0] <= ex_valid && ex_md_start; hmd_d[0] <= ex_dest;
            for (int a = 1; a < 8; a++) begin
                hld_v[a] <= hld_v[a-1]; hld_d[a] <= hld_d[a-1];
                hmd_v[a] <= hmd_v[a-1]; hmd_d[a] <= hmd_d[a-1];
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("stall[%0d]", i), {31'b0, st[i]}, {31'b0, m_stall(i)});
            chk($sformatf("bubble_ex[%0d]", i), {31'b0, bb[i]}, {31'b0, m_stall(i)});
            chk($sformatf("md_busy[%0d]", i), {31'b0, mb[i]}, {31'b0, m_busy(i)});
            chk($sformatf("stall_cnt[%0d]", i), {16'b0, cnt[i]}, mcnt[i]);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_is_md = 0; id_rs = 0; id_rt = 0;
        ex_valid = 0; ex_memread = 0; ex_md_start = 0; ex_dest = 0; flush = 0;
    endtask

    task automatic do_reset();
        cyc(); idle(); rst = 1;
        cyc(); cyc(); rst = 0;
    endtask

    task automatic id_reads(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut);
        id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = ur; id_use_rt = ut; id_is_md = 0;
    endtask

    task automatic ex_op(input logic v, input logic ld, input logic md, input logic [4:0] d);
        ex_valid = v; ex_memread = ld; ex_md_start = md; ex_dest = d;
    endtask

    int seq [5];

    initial begin
        seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 3; seq[4] = 3;
        do_reset();
        @(negedge clk);
        chk("reset stall_cnt", {16'b0, cnt[0]}, 0);
        chk("reset md_busy", {31'b0, mb[0]}, 0);

        // lw r5; add r1,r5,r2
        cyc(); id_reads(5, 2, 1, 1); ex_op(1, 1, 0, 5);
        @(negedge clk);
        chk("ld2 stall c0", {31'b0, st[0]}, 1);
        chk("ld3 stall c0", {31'b0, st[1]}, 1);
        chk("ld1 stall c0", {31'b0, st[2]}, 0);
        cyc(); ex_op(0, 0, 0, 0);
        @(negedge clk);
        chk("ld2 stall c1", {31'b0, st[0]}, 0);
        chk("ld3 stall c1", {31'b0, st[1]}, 1);
        chk("ld2 stall_cnt", {16'b0, cnt[0]}, 1);
        cyc();
        @(negedge clk);
        chk("ld3 stall c2", {31'b0, st[1]}, 0);

        // Independent reader, r0 load, unused matching rt.
        do_reset();
        cyc(); id_reads(6, 0, 1, 0); ex_op(1, 1, 0, 5);
        @(negedge clk); chk("ld other reg", {31'b0, st[1]}, 0);
        cyc(); id_reads(0, 0, 1, 1); ex_op(1, 1, 0, 0);
        @(negedge clk); chk("ld r0", {31'b0, st[1]}, 0);
        cyc(); id_reads(1, 9, 1, 0); ex_op(1, 1, 0, 9);
        @(negedge clk); chk("ld unused rt", {31'b0, st[0]}, 0);

        // mul r7 then a dependent reader: three stall cycles.
        do_reset();
        cyc(); id_reads(7, 0, 1, 0); ex_op(1, 0, 1, 7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("md dep c%0d", k), {31'b0, st[0]}, (k < 3) ? 1 : 0);
            cyc(); ex_op(0, 0, 0, 0);
        end

        // Independent md op behind a running md op.
        do_reset();
        cyc(); id_reads(1, 2, 0, 0); id_is_md = 1; ex_op(1, 0, 1, 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("md struct c%0d", k), {31'b0, st[0]}, (k < 3) ? 1 : 0);
            chk($sformatf("md busy c%0d", k), {31'b0, mb[0]}, (k < 4) ? 1 : 0);
            cyc(); ex_op(0, 0, 0, 0);
        end

        // Flush masks a load hazard.
        do_reset();
        cyc(); id_reads(5, 0, 1, 0); ex_op(1, 1, 0, 5); flush = 1;
        @(negedge clk); chk("flush stall", {31'b0, st[0]}, 0);

        // Reset during an md stall drops it at once.
        do_reset();
        cyc(); id_reads(7, 0, 1, 0); ex_op(1, 0, 1, 7);
        cyc(); ex_op(0, 0, 0, 0);
        @(negedge clk); chk("md pre-rst stall", {31'b0, st[0]}, 1);
        #2 rst = 1;
        #1;
        chk("rst stall", {31'b0, st[0]}, 0);
        chk("rst md_busy", {31'b0, mb[0]}, 0);
        cyc(); rst = 0;

        // Saturation of the 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(); id_reads(7, 0, 1, 0); ex_op(1, 0, 1, 7);
            @(negedge clk);
            if (k > 0) chk($sformatf("sat cnt %0d", k - 1), {30'b0, cnt_b}, seq[k-1]);
        end
        cyc(); idle();
        @(negedge clk); chk("sat cnt 4", {30'b0, cnt_b}, seq[4]);

        // Randomized traffic on small register numbers to provoke matches.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cyc();
            rst = ($urandom_range(0, 99) == 0);
            id_valid = ($urandom_range(0, 9) < 8);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_is_md = ($urandom_range(0, 4) == 0);
            ex_valid = ($urandom_range(0, 9) < 7);
            ex_memread = ($urandom_range(0, 9) < 3);
            ex_md_start = ($urandom_range(0, 19) < 3);
            ex_dest = 5'($urandom_range(0, 3));
            flush = ($urandom_range(0, 9) == 0);
        end
        cyc(); idle(); rst = 0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
